fact_bcd_conv: RTL

Downstream stage of the factorial unit. Captures the 16-bit factorial result on the factorial unit's done pulse and converts it to 5 packed BCD digits using a sequential shift-add-3 (double-dabble) loop, one bit per clock. The packed BCD word feeds the display/readout path. Single-cycle result strobe; no backpressure.

---
 rtl/fact_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 20 ++
 rtl/fact_bcd_conv.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// ---------------------------------------------------------------------------
// fact_pkg
// Shared constants and types for the factorial result readout path.
//   FACT_W     : width of the binary factorial result
//   BCD_DIGITS : number of packed BCD digits produced
//   BCD_W      : width of the packed BCD word
//   BLANK_CODE : nibble used for a blanked leading digit
//   state_t    : converter sequencing states
// ---------------------------------------------------------------------------
package fact_pkg;

   localparam int        FACT_W     = 16;
   localparam int        BCD_DIGITS = 5;
   localparam int        BCD_W      = 4 * BCD_DIGITS;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 correction for one BCD digit of the double-dabble
// accumulator: a digit of 5 or more gets 3 added, so that the following left
// shift carries correctly into the next decade. No carry out of the digit.
// Ports:
//   i_digit : current 4-bit digit
//   o_digit : corrected 4-bit digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
   import fact_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // Pure 4-bit correction; inputs never exceed 9 so no wrap occurs.
   assign o_digit = (i_digit >= 4'd5) ? 4'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/fact_bcd_conv.sv
// ---------------------------------------------------------------------------
// fact_bcd_conv
// Captures the factorial result on its done strobe and converts it to packed
// BCD with a sequential shift-add-3 loop, one binary bit per clock.
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_valid  : capture strobe (factorial done)
//   din       : binary value to convert
//   busy      : conversion in progress, new strobes are ignored
//   out_valid : one-cycle strobe, bcd_out has just been updated
//   bcd_out   : packed BCD, most significant digit in the top nibble
//   dropped   : sticky flag, a strobe arrived while busy
// Optional build macro:
//   FACT_BCD_BLANK_EN : leading zero digits (never digit 0) are loaded as
//                       BLANK_CODE instead of 0.
// ---------------------------------------------------------------------------
module fact_bcd_conv
   import fact_pkg::*;
#(
   parameter int BIN_W  = FACT_W,
   parameter int DIGITS = BCD_DIGITS
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [BIN_W-1:0]      din,
   output logic                  busy,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  dropped
);

   localparam int               CNT_W    = $clog2(BIN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t              r_state;
   logic [BIN_W-1:0]    r_bin;
   logic [4*DIGITS-1:0] r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_outValid;
   logic [4*DIGITS-1:0] r_bcdOut;
   logic                r_dropped;

   logic [4*DIGITS-1:0] w_adj;
   logic [4*DIGITS-1:0] w_accNext;
   logic [4*DIGITS-1:0] w_load;

   // One correction cell per digit, all evaluated in parallel on the
   // current accumulator before it is shifted.
   for (genvar g = 0; g < DIGITS; g++) begin : gDigit
      bcd_digit_adj uAdj (
         .i_digit (r_acc[4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end

   // Accumulator after this edge's shift: corrected digits move up one bit
   // and the binary MSB enters at the bottom.
   assign w_accNext = {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};

`ifdef FACT_BCD_BLANK_EN
   logic w_lead;

   // Walk from the top digit down, replacing zeros until the first nonzero
   // digit; the units digit always shows so a zero result reads as "0".
   always_comb begin
      w_load = w_accNext;
      w_lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (w_lead && (w_accNext[4*k +: 4] == 4'd0)) begin
            w_load[4*k +: 4] = BLANK_CODE;
         end else begin
            w_lead = 1'b0;
         end
      end
   end
`else
   assign w_load = w_accNext;
`endif

   // Sequencer: IDLE accepts a value, SHIFT runs BIN_W iterations and loads
   // the result on the last one. Outputs are registered here so out_valid is
   // a clean single-cycle strobe and bcd_out only moves on that load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_outValid <= 1'b0;
         r_bcdOut   <= '0;
         r_dropped  <= 1'b0;
      end else begin
         r_outValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_bin   <= din;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (in_valid) begin
                  r_dropped <= 1'b1;
               end
               r_acc <= w_accNext;
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_bcdOut   <= w_load;
                  r_outValid <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign out_valid = r_outValid;
   assign bcd_out   = r_bcdOut;
   assign dropped   = r_dropped;

endmodule
